// File: rtl/axi4_vip_rtl_pkg.sv
// Shared AXI4 response/burst codes and FSM state types
// for the slave memory responder.
package axi4_vip_rtl_pkg;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle with master and slave views.
// Clock and reset travel as separate scalar ports.
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) ();
    localparam int NB = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [NB-1:0]         wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst,
        output awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst,
        input  awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts and
// legality check of the burst descriptor.
module axi4_burst_addr_gen
    import axi4_vip_rtl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic                  err_o
);
    localparam int NB_LOG2 = $clog2(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic                  wrap_len_ok;

    always_comb begin
        step = ADDR_WIDTH'(1) << size_i;
        incr = addr_i + step;
        // Wrap window is (len+1) beats, a power of two when legal
        wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i)
                  - ADDR_WIDTH'(1);
        wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3)
                   || (len_i == 8'd7) || (len_i == 8'd15);
        err_o = (size_i > 3'(NB_LOG2))
             || (burst_i == BURST_RSVD)
             || ((burst_i == BURST_WRAP) && !wrap_len_ok);
        unique case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = incr;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask)
                                     | (incr & wrap_mask);
            default:     next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi4_slave_mem_responder.sv
// AXI4 slave backed by a byte-enabled word memory, with
// independent write and read burst engines.
module axi4_slave_mem_responder
    import axi4_vip_rtl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic        clk,
    input  logic        rst,
    axi4_if.slave       s_if,
    output logic [15:0] wr_txn_cnt,
    output logic [15:0] rd_txn_cnt
);
    localparam int NB       = DATA_WIDTH / 8;
    localparam int NB_LOG2  = $clog2(NB);
    localparam int MEM_LOG2 = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    wr_state_e             ws_q, ws_d;
    logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            aw_len_q, aw_len_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic [1:0]            aw_burst_q, aw_burst_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic                  wlast_err_q, wlast_err_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic                  mem_we;
    logic                  w_last_beat;
    logic [ADDR_WIDTH-1:0] w_next;
    logic                  w_err;
    logic [MEM_LOG2-1:0]   w_idx;

    rd_state_e             rs_q, rs_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [2:0]            r_size_q, r_size_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] rg_addr;
    logic [7:0]            rg_len;
    logic [2:0]            rg_size;
    logic [1:0]            rg_burst;
    logic [ADDR_WIDTH-1:0] r_next;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_fetch_addr;
    logic [MEM_LOG2-1:0]   r_idx;

    logic unused_sideband;
    assign unused_sideband = ^{s_if.awlock, s_if.awcache,
                               s_if.awprot, s_if.awqos,
                               s_if.awregion, s_if.arlock,
                               s_if.arcache, s_if.arprot,
                               s_if.arqos, s_if.arregion};

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_gen (
        .addr_i      (w_addr_q),
        .len_i       (aw_len_q),
        .size_i      (aw_size_q),
        .burst_i     (aw_burst_q),
        .next_addr_o (w_next),
        .err_o       (w_err)
    );

    // In R_IDLE the generator judges the incoming AR descriptor
    assign rg_addr  = (rs_q == R_IDLE) ? s_if.araddr  : r_addr_q;
    assign rg_len   = (rs_q == R_IDLE) ? s_if.arlen   : r_len_q;
    assign rg_size  = (rs_q == R_IDLE) ? s_if.arsize  : r_size_q;
    assign rg_burst = (rs_q == R_IDLE) ? s_if.arburst : r_burst_q;

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_gen (
        .addr_i      (rg_addr),
        .len_i       (rg_len),
        .size_i      (rg_size),
        .burst_i     (rg_burst),
        .next_addr_o (r_next),
        .err_o       (r_err)
    );

    assign w_idx        = w_addr_q[NB_LOG2 +: MEM_LOG2];
    assign r_fetch_addr = (rs_q == R_IDLE) ? s_if.araddr : r_next;
    assign r_idx        = r_fetch_addr[NB_LOG2 +: MEM_LOG2];
    assign w_last_beat  = (w_cnt_q == aw_len_q);

    always_comb begin
        ws_d        = ws_q;
        aw_id_d     = aw_id_q;
        w_addr_d    = w_addr_q;
        aw_len_d    = aw_len_q;
        aw_size_d   = aw_size_q;
        aw_burst_d  = aw_burst_q;
        w_cnt_d     = w_cnt_q;
        wlast_err_d = wlast_err_q;
        bresp_d     = bresp_q;
        wr_cnt_d    = wr_cnt_q;
        mem_we      = 1'b0;
        unique case (ws_q)
            W_IDLE: begin
                if (s_if.awvalid) begin
                    aw_id_d     = s_if.awid;
                    w_addr_d    = s_if.awaddr;
                    aw_len_d    = s_if.awlen;
                    aw_size_d   = s_if.awsize;
                    aw_burst_d  = s_if.awburst;
                    w_cnt_d     = 8'd0;
                    wlast_err_d = 1'b0;
                    ws_d        = W_DATA;
                end
            end
            W_DATA: begin
                if (s_if.wvalid) begin
                    mem_we   = !w_err;
                    w_addr_d = w_next;
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (s_if.wlast != w_last_beat) begin
                        wlast_err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        ws_d    = W_RESP;
                        bresp_d = (w_err || wlast_err_q || !s_if.wlast)
                                ? AXI_SLVERR : AXI_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (s_if.bready) begin
                    ws_d     = W_IDLE;
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end
            end
            default: ws_d = W_IDLE;
        endcase
    end

    always_comb begin
        rs_d      = rs_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rd_cnt_d  = rd_cnt_q;
        unique case (rs_q)
            R_IDLE: begin
                if (s_if.arvalid) begin
                    r_id_d    = s_if.arid;
                    r_addr_d  = s_if.araddr;
                    r_len_d   = s_if.arlen;
                    r_size_d  = s_if.arsize;
                    r_burst_d = s_if.arburst;
                    r_cnt_d   = 8'd0;
                    rdata_d   = r_err ? '0 : mem_q[r_idx];
                    rresp_d   = r_err ? AXI_SLVERR : AXI_OKAY;
                    rlast_d   = (s_if.arlen == 8'd0);
                    rs_d      = R_DATA;
                end
            end
            R_DATA: begin
                if (s_if.rready) begin
                    if (rlast_q) begin
                        rs_d     = R_IDLE;
                        rlast_d  = 1'b0;
                        rd_cnt_d = rd_cnt_q + 16'd1;
                    end else begin
                        // Fetch the following beat for next cycle
                        r_addr_d = r_next;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        rdata_d  = r_err ? '0 : mem_q[r_idx];
                        rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: rs_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ws_q        <= W_IDLE;
            aw_id_q     <= '0;
            w_addr_q    <= '0;
            aw_len_q    <= '0;
            aw_size_q   <= '0;
            aw_burst_q  <= '0;
            w_cnt_q     <= '0;
            wlast_err_q <= 1'b0;
            bresp_q     <= '0;
            wr_cnt_q    <= '0;
            rs_q        <= R_IDLE;
            r_id_q      <= '0;
            r_addr_q    <= '0;
            r_len_q     <= '0;
            r_size_q    <= '0;
            r_burst_q   <= '0;
            r_cnt_q     <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            rlast_q     <= 1'b0;
            rd_cnt_q    <= '0;
        end else begin
            ws_q        <= ws_d;
            aw_id_q     <= aw_id_d;
            w_addr_q    <= w_addr_d;
            aw_len_q    <= aw_len_d;
            aw_size_q   <= aw_size_d;
            aw_burst_q  <= aw_burst_d;
            w_cnt_q     <= w_cnt_d;
            wlast_err_q <= wlast_err_d;
            bresp_q     <= bresp_d;
            wr_cnt_q    <= wr_cnt_d;
            rs_q        <= rs_d;
            r_id_q      <= r_id_d;
            r_addr_q    <= r_addr_d;
            r_len_q     <= r_len_d;
            r_size_q    <= r_size_d;
            r_burst_q   <= r_burst_d;
            r_cnt_q     <= r_cnt_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    // Storage survives reset; only live beats are blocked
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < NB; b++) begin
                if (s_if.wstrb[b]) begin
                    mem_q[w_idx][8*b +: 8] <= s_if.wdata[8*b +: 8];
                end
            end
        end
    end

    assign s_if.awready = (ws_q == W_IDLE);
    assign s_if.wready  = (ws_q == W_DATA);
    assign s_if.bvalid  = (ws_q == W_RESP);
    assign s_if.bid     = aw_id_q;
    assign s_if.bresp   = bresp_q;

    assign s_if.arready = (rs_q == R_IDLE);
    assign s_if.rvalid  = (rs_q == R_DATA);
    assign s_if.rid     = r_id_q;
    assign s_if.rdata   = rdata_q;
    assign s_if.rresp   = rresp_q;
    assign s_if.rlast   = rlast_q;

    assign wr_txn_cnt = wr_cnt_q;
    assign rd_txn_cnt = rd_cnt_q;

endmodule

// File: doc/axi4_slave_mem_responder.md
AXI4_SLAVE_MEM_RESPONDER -- requirements
Module: axi4_slave_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI data width in bits; byte lanes NB = DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-004 SHALL have parameter MEM_DEPTH, default 256, storage depth in DATA_WIDTH words (power of 2).
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port s_if  interface  axi4_if.slave  AXI4 slave port, driven by one interconnect slave-side port; awlock/awcache/awprot/awqos/awregion and the matching AR fields are accepted and ignored.
REQ-008 SHALL have port wr_txn_cnt  output  16  count of completed write responses (B handshakes).
REQ-009 SHALL have port rd_txn_cnt  output  16  count of completed read bursts (R handshakes with rlast).

Function
REQ-010 SHALL run independent write and read FSMs; the two channels never stall each other.
REQ-011 Write FSM states: W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; an AW handshake captures id/addr/len/size/burst, clears beat counter, goes to W_DATA.
REQ-012 In W_DATA wready=1; each W handshake writes the lanes enabled by wstrb to mem[word index]; W_DATA -> W_RESP on the handshake where beat counter == len.
REQ-013 In W_RESP bvalid=1 with bid=captured id; bvalid, bid and bresp held stable until bready; B handshake -> W_IDLE and wr_txn_cnt+1.
REQ-014 Word index = addr[log2(NB) +: log2(MEM_DEPTH)]; higher address bits ignored (aliasing wraps modulo MEM_DEPTH).
REQ-015 Beat address: FIXED unchanged; INCR += 2^size; WRAP += 2^size, wrapping at an aligned boundary of (len+1)*2^size bytes.
REQ-016 SLVERR (2'b10) for: size > log2(NB), burst == 2'b11, or WRAP with len not in {1,3,7,15}; such writes consume len+1 beats but modify no memory, and such reads return rdata=0 on every beat.
REQ-017 wlast mismatch (asserted before beat len, or deasserted on beat len) SHALL give bresp=SLVERR; exactly len+1 beats consumed, data still written; otherwise bresp=OKAY.
REQ-018 Read FSM states: R_IDLE, R_DATA; arready=1 only in R_IDLE; AR handshake in cycle N -> first rvalid in cycle N+1.
REQ-019 In R_DATA rid=captured id, rlast=1 only on beat len; rdata/rresp/rlast held stable while rvalid && !rready.
REQ-020 After an R handshake that is not last, the next beat SHALL be presented the following cycle (one beat per cycle at rready=1); R handshake with rlast -> R_IDLE, rd_txn_cnt+1.
REQ-021 Same-cycle write and read of one word: a read beat already presented keeps its data; beats loaded after the write cycle see the new data.
REQ-022 wr_txn_cnt and rd_txn_cnt wrap 0xFFFF -> 0x0000.

Reset
REQ-023 While rst=1: both FSMs to IDLE, awready=arready=1 on the first cycle after release, wready=bvalid=rvalid=rlast=0, bresp=rresp=0, bid=rid=0, rdata=0, counters=0.
REQ-024 Reset mid-burst SHALL abandon the burst with no response issued; memory contents are not reset and keep all completed writes.

Structure
REQ-025 Shared package axi4_vip_rtl_pkg SHALL hold the AXI response codes (OKAY, SLVERR), the burst type codes (FIXED, INCR, WRAP), and the write/read FSM state typedefs.
REQ-026 Sub-module axi4_burst_addr_gen (next-address computation per REQ-015, legality check per REQ-016) SHALL be instantiated once for write and once for read.
REQ-027 Storage SHALL be a single MEM_DEPTH x DATA_WIDTH array with byte-write enables.

Verification
REQ-028 INCR write, awaddr=0x100, len=3, size=3, wstrb=0xFF, data 0xA0..A3 -> bresp=OKAY; INCR read of the same -> 4 beats 0xA0..A3, rlast on beat 3, rid=awid.
REQ-029 WRAP read araddr=0x118, len=3, size=3 -> beat addresses 0x118, 0x100, 0x108, 0x110.
REQ-030 Write with wlast on beat 1 of len=3 -> 4 beats accepted, bresp=2'b10; write awsize=4 (64-bit bus) -> bresp=2'b10, memory unchanged.
REQ-031 rready toggling 1/0 each cycle during 8-beat read -> rdata held stable on stall cycles, no beat lost or duplicated; bready held 0 for 5 cycles -> bvalid and bid stable.
REQ-032 rst pulsed in W_DATA after 2 of 4 beats -> no bvalid, awready=1 after release, the 2 written words persist; concurrent write and read bursts -> both channels complete, counters each +1.
